// File: rtl/ets_sweep_controller.sv
// Equivalent-time-sampling sweep sequencer: runs the offset sampler once per ETS phase
// offset, buffers each 32-bit result in a FWFT FIFO and steps the ETS clock phase between runs.
module ets_sweep_controller #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic [15:0]                   num_steps,
    input  logic                          sampler_running,
    input  logic                          sampler_result_ready,
    input  logic [31:0]                   sampler_result,
    output logic                          sampler_request_run,
    output logic                          phase_step,
    input  logic                          phase_step_ack,
    output logic                          busy,
    output logic                          sweep_done,
    output logic [15:0]                   step_index,
    input  logic                          fifo_rd,
    input  logic                          fifo_clear,
    output logic [31:0]                   fifo_data,
    output logic                          fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE   = AW'(1'b1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_ARM         = 3'd1,
        S_REQUEST     = 3'd2,
        S_WAIT_RESULT = 3'd3,
        S_STEP        = 3'd4,
        S_WAIT_ACK    = 3'd5,
        S_DONE        = 3'd6
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [15:0]     num_steps_r;
    logic [15:0]     step_index_r;
    logic            overflow_r;
    logic [31:0]     mem_r [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;

    logic            start_acc_s;
    logic            ack_acc_s;
    logic            last_step_s;
    logic            fifo_wr_s;
    logic            fifo_full_s;
    logic            rd_ok_s;
    logic            wr_ok_s;
    logic            drop_s;

    // abort outranks every handshake, so all accept strobes are masked by it
    assign start_acc_s = (state_r == S_IDLE) && start && !abort;
    assign ack_acc_s   = (state_r == S_WAIT_ACK) && phase_step_ack && !abort;
    assign fifo_wr_s   = (state_r == S_WAIT_RESULT) && sampler_result_ready && !abort;
    assign last_step_s = (step_index_r == (num_steps_r - 16'd1));

    assign fifo_full_s = (count_r == CNT_FULL);
    assign rd_ok_s     = fifo_rd && (count_r != '0);
    assign wr_ok_s     = fifo_wr_s && (!fifo_full_s || rd_ok_s);
    assign drop_s      = fifo_wr_s && fifo_full_s && !rd_ok_s && !fifo_clear;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        if (abort) begin
            state_nxt_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        state_nxt_s = (num_steps == 16'd0) ? S_DONE : S_ARM;
                    end else begin
                        state_nxt_s = S_IDLE;
                    end
                end
                S_ARM: begin
                    if (!sampler_running) begin
                        state_nxt_s = S_REQUEST;
                    end else begin
                        state_nxt_s = S_ARM;
                    end
                end
                S_REQUEST: begin
                    if (sampler_running) begin
                        state_nxt_s = S_WAIT_RESULT;
                    end else begin
                        state_nxt_s = S_REQUEST;
                    end
                end
                S_WAIT_RESULT: begin
                    if (sampler_result_ready) begin
                        state_nxt_s = last_step_s ? S_DONE : S_STEP;
                    end else begin
                        state_nxt_s = S_WAIT_RESULT;
                    end
                end
                S_STEP:     state_nxt_s = S_WAIT_ACK;
                S_WAIT_ACK: begin
                    if (phase_step_ack) begin
                        state_nxt_s = S_ARM;
                    end else begin
                        state_nxt_s = S_WAIT_ACK;
                    end
                end
                S_DONE:     state_nxt_s = S_IDLE;
                default:    state_nxt_s = S_IDLE;
            endcase
        end
    end

    // Sweep length latch and offset counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_steps_r  <= 16'd0;
            step_index_r <= 16'd0;
        end else if (abort) begin
            step_index_r <= 16'd0;
        end else if (start_acc_s) begin
            num_steps_r  <= num_steps;
            step_index_r <= 16'd0;
        end else if (ack_acc_s) begin
            step_index_r <= step_index_r + 16'd1;
        end else begin
            step_index_r <= step_index_r;
        end
    end

    // Sticky overflow: only a new sweep or reset clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r <= 1'b0;
        end else if (start_acc_s) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    // FIFO pointers and occupancy; clear wins over same-cycle read/write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (fifo_clear) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (rd_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({wr_ok_s, rd_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage; contents are qualified by count, so no reset is needed
    always_ff @(posedge clk) begin
        if (wr_ok_s && !fifo_clear) begin
            mem_r[wr_ptr_r] <= sampler_result;
        end
    end

    assign sampler_request_run = (state_r == S_REQUEST);
    assign phase_step          = (state_r == S_STEP);
    assign busy                = (state_r != S_IDLE);
    assign sweep_done          = (state_r == S_DONE);
    assign step_index          = step_index_r;
    assign overflow            = overflow_r;
    assign fifo_count          = count_r;
    assign fifo_empty          = (count_r == '0);
    assign fifo_data           = mem_r[rd_ptr_r];

endmodule

// File: tb/tb_ets_sweep_controller.sv
// Bench for ets_sweep_controller: behavioural sampler / phase-logic models drive the DUT,
// a queue-based FIFO reference is checked every cycle, plus table-driven and corner sweeps.
module tb_ets_sweep_controller;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] num_steps;
    logic        sampler_running;
    logic        sampler_result_ready;
    logic [31:0] sampler_result;
    logic        sampler_request_run;
    logic        phase_step;
    logic        phase_step_ack;
    logic        busy;
    logic        sweep_done;
    logic [15:0] step_index;
    logic        fifo_rd;
    logic        fifo_clear;
    logic [31:0] fifo_data;
    logic        fifo_empty;
    logic [4:0]  fifo_count;
    logic        overflow;

    ets_sweep_controller #(.FIFO_DEPTH(DEPTH)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .start                (start),
        .abort                (abort),
        .num_steps            (num_steps),
        .sampler_running      (sampler_running),
        .sampler_result_ready (sampler_result_ready),
        .sampler_result       (sampler_result),
        .sampler_request_run  (sampler_request_run),
        .phase_step           (phase_step),
        .phase_step_ack       (phase_step_ack),
        .busy                 (busy),
        .sweep_done           (sweep_done),
        .step_index           (step_index),
        .fifo_rd              (fifo_rd),
        .fifo_clear           (fifo_clear),
        .fifo_data            (fifo_data),
        .fifo_empty           (fifo_empty),
        .fifo_count           (fifo_count),
        .overflow             (overflow)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // reference FIFO and sticky overflow
    logic [31:0] mq[$];
    bit          movf;
    bit          mon_en;

    // sampler / phase-logic behavioural models
    int          smp_st, smp_cnt, s_lat, s_ackd, ph_cnt, res_idx;
    bit          smp_hold;
    logic [31:0] res_tab [32];
    bit          rand_rd;
    int          wr_mode;   // 0 none, 1 read on write strobe, 2 clear on write strobe

    logic        prev_req;
    int          req_rises, step_cycles, done_cycles;

    typedef struct {
        int n;
        int lat;
        int ackd;
        int exp_req;
        int exp_step;
        int exp_done;
    } sweep_vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        movf = 1'b0;
        smp_st = 0; smp_cnt = 0; ph_cnt = 0; res_idx = 0;
        sampler_result_ready = 1'b0;
        sampler_running = smp_hold;
        phase_step_ack = 1'b0;
    endtask

    // One clock: update FIFO reference from the inputs seen at the edge, check, then drive models
    task automatic cycle();
        bit          w, r, c, s, rok, wok;
        logic [31:0] wd;
        w  = sampler_result_ready;
        wd = sampler_result;
        r  = fifo_rd;
        c  = fifo_clear;
        s  = start && !abort;
        @(posedge clk);
        #1;
        if (c) begin
            mq.delete();
        end else begin
            rok = r && (mq.size() > 0);
            wok = w && ((mq.size() < DEPTH) || rok);
            if (rok) void'(mq.pop_front());
            if (wok) mq.push_back(wd);
            else if (w) movf = 1'b1;
        end
        if (s) movf = 1'b0;
        if (mon_en) begin
            chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
            chk("fifo_empty", 32'(fifo_empty), 32'(mq.size() == 0));
            chk("overflow", 32'(overflow), 32'(movf));
            if (mq.size() > 0) chk("fifo_data", fifo_data, mq[0]);
        end
        if (sampler_request_run && !prev_req) req_rises++;
        prev_req = sampler_request_run;
        if (phase_step) step_cycles++;
        if (sweep_done) done_cycles++;
        sampler_result_ready = 1'b0;
        case (smp_st)
            0: if (sampler_request_run && !smp_hold) begin smp_st = 1; smp_cnt = s_lat; end
            1: begin
                smp_cnt--;
                if (smp_cnt == 0) begin
                    sampler_result_ready = 1'b1;
                    sampler_result = res_tab[res_idx];
                    res_idx++;
                    smp_st = 2;
                end
            end
            default: smp_st = 0;
        endcase
        sampler_running = smp_hold || (smp_st != 0);
        phase_step_ack = 1'b0;
        if (ph_cnt > 0) begin
            ph_cnt--;
            if (ph_cnt == 0) phase_step_ack = 1'b1;
        end
        if (phase_step) ph_cnt = s_ackd;
        if (rand_rd) fifo_rd = ($urandom_range(0, 2) == 0);
        else if (wr_mode == 1) fifo_rd = sampler_result_ready;
        if (wr_mode == 2) fifo_clear = sampler_result_ready;
    endtask

    task automatic wait_done();
        int b;
        b = 0;
        while (!(done_cycles > 0 && !busy) && b < 3000) begin
            cycle();
            b++;
        end
        if (b >= 3000) begin
            vectors++;
            miscompares++;
            $display("FAIL sweep_timeout: got %0d cycles, expected fewer than 3000", b);
        end
        rand_rd = 1'b0;
        fifo_rd = 1'b0;
    endtask

    task automatic begin_sweep(input int n, input int lat, input int ackd, input bit rnd);
        for (int i = 0; i < 32; i++) res_tab[i] = rnd ? $urandom : 32'(10 * (i + 1));
        num_steps = 16'(n);
        s_lat = lat; s_ackd = ackd; res_idx = 0;
        req_rises = 0; step_cycles = 0; done_cycles = 0;
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic run_sweep(input int n, input int lat, input int ackd, input bit rr, input bit rnd);
        begin_sweep(n, lat, ackd, rnd);
        chk("start_done", 32'(sweep_done), 32'(n == 0));
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_req", 32'(sampler_request_run), 32'd0);
        rand_rd = rr;
        wait_done();
    endtask

    task automatic clear_fifo();
        fifo_clear = 1'b1;
        cycle();
        fifo_clear = 1'b0;
    endtask

    task automatic drain_expect(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            chk("drain_data", fifo_data, 32'(10 * (i + 1)));
            fifo_rd = 1'b1;
            cycle();
            fifo_rd = 1'b0;
        end
        chk("drain_empty", 32'(fifo_empty), 32'd1);
    endtask

    sweep_vec_t vecs [5];

    initial begin
        vecs[0] = '{n: 0, lat: 1, ackd: 1, exp_req: 0, exp_step: 0, exp_done: 1};
        vecs[1] = '{n: 1, lat: 2, ackd: 2, exp_req: 1, exp_step: 0, exp_done: 1};
        vecs[2] = '{n: 2, lat: 1, ackd: 1, exp_req: 2, exp_step: 1, exp_done: 1};
        vecs[3] = '{n: 4, lat: 2, ackd: 3, exp_req: 4, exp_step: 3, exp_done: 1};
        vecs[4] = '{n: 3, lat: 4, ackd: 5, exp_req: 3, exp_step: 2, exp_done: 1};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; num_steps = 16'd0;
        fifo_rd = 1'b0; fifo_clear = 1'b0; sampler_result = 32'd0;
        smp_hold = 1'b0; rand_rd = 1'b0; wr_mode = 0; mon_en = 1'b0;
        prev_req = 1'b0; s_lat = 1; s_ackd = 1;
        model_reset();
        #12;
        chk("rst_req", 32'(sampler_request_run), 32'd0);
        chk("rst_phase", 32'(phase_step), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(sweep_done), 32'd0);
        chk("rst_step_index", 32'(step_index), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_empty", 32'(fifo_empty), 32'd1);
        chk("rst_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        cycle();

        // table-driven sweeps
        for (int v = 0; v < 5; v++) begin
            clear_fifo();
            run_sweep(vecs[v].n, vecs[v].lat, vecs[v].ackd, 1'b0, 1'b0);
            chk("tab_requests", 32'(req_rises), 32'(vecs[v].exp_req));
            chk("tab_phase_steps", 32'(step_cycles), 32'(vecs[v].exp_step));
            chk("tab_sweep_done", 32'(done_cycles), 32'(vecs[v].exp_done));
            chk("tab_count", 32'(fifo_count), 32'(vecs[v].n));
            chk("tab_overflow", 32'(overflow), 32'd0);
            drain_expect(vecs[v].n);
        end

        // overflow: 20 results into 16 entries, then a new start clears the flag
        clear_fifo();
        run_sweep(20, 1, 1, 1'b0, 1'b0);
        chk("ovf_count", 32'(fifo_count), 32'd16);
        chk("ovf_flag", 32'(overflow), 32'd1);
        drain_expect(16);
        chk("ovf_kept", 32'(overflow), 32'd1);
        run_sweep(1, 1, 1, 1'b0, 1'b0);
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // sampler held busy: stay in ARM, spurious ack ignored, request one cycle after release
        clear_fifo();
        smp_hold = 1'b1;
        sampler_running = 1'b1;
        cycle();
        begin_sweep(2, 1, 2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("arm_hold_req", 32'(sampler_request_run), 32'd0);
            chk("arm_hold_busy", 32'(busy), 32'd1);
            cycle();
        end
        phase_step_ack = 1'b1;
        cycle();
        chk("arm_spurious_ack", 32'(step_index), 32'd0);
        smp_hold = 1'b0;
        sampler_running = 1'b0;
        cycle();
        chk("req_after_release", 32'(sampler_request_run), 32'd1);
        wait_done();
        chk("arm_requests", 32'(req_rises), 32'd2);
        drain_expect(2);

        // abort in WAIT_ACK with two stored results
        clear_fifo();
        begin_sweep(5, 1, 8, 1'b0);
        for (int b = 0; b < 500 && step_cycles < 2; b++) cycle();
        cycle();
        chk("pre_abort_index", 32'(step_index), 32'd1);
        chk("pre_abort_count", 32'(fifo_count), 32'd2);
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_index", 32'(step_index), 32'd0);
        chk("abort_count", 32'(fifo_count), 32'd2);
        chk("abort_phase", 32'(phase_step), 32'd0);
        ph_cnt = 0;
        cycle();

        // asynchronous reset mid-sweep
        begin_sweep(6, 2, 2, 1'b0);
        repeat (12) cycle();
        rst_n = 1'b0;
        #2;
        chk("arst_req", 32'(sampler_request_run), 32'd0);
        chk("arst_phase", 32'(phase_step), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_index", 32'(step_index), 32'd0);
        chk("arst_count", 32'(fifo_count), 32'd0);
        chk("arst_empty", 32'(fifo_empty), 32'd1);
        model_reset();
        #2;
        rst_n = 1'b1;
        cycle();

        // full FIFO with a write and read in the same cycle
        run_sweep(16, 1, 1, 1'b0, 1'b0);
        chk("full_count", 32'(fifo_count), 32'd16);
        wr_mode = 1;
        run_sweep(1, 1, 1, 1'b0, 1'b0);
        wr_mode = 0;
        chk("full_rw_count", 32'(fifo_count), 32'd16);
        chk("full_rw_head", fifo_data, 32'd20);
        chk("full_rw_overflow", 32'(overflow), 32'd0);

        // clear beats a same-cycle write
        wr_mode = 2;
        run_sweep(1, 1, 1, 1'b0, 1'b0);
        wr_mode = 0;
        fifo_clear = 1'b0;
        chk("clear_vs_write", 32'(fifo_count), 32'd0);

        // randomized sweeps with random host reads
        for (int k = 0; k < 6; k++) begin
            int n;
            n = $urandom_range(1, 12);
            run_sweep(n, $urandom_range(1, 4), $urandom_range(1, 5), 1'b1, 1'b1);
            chk("rnd_requests", 32'(req_rises), 32'(n));
            chk("rnd_phase_steps", 32'(step_cycles), 32'(n - 1));
            chk("rnd_sweep_done", 32'(done_cycles), 32'd1);
        end
        while (mq.size() > 0) begin
            fifo_rd = 1'b1;
            cycle();
        end
        fifo_rd = 1'b0;
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ets_sweep_controller.md
# ets_sweep_controller

Sequences an equivalent-time-sampling sweep: for each of `num_steps` ETS phase offsets it triggers one offset-sampler run, captures the sampler's 32-bit one-count result into an internal FIFO, then requests a one-increment phase advance of the ETS clock and waits for the phase logic to acknowledge. It sits between the host register interface, the offset sampler (drives `request_run`, consumes `result_ready`/`result`) and the ETS clock phase-shift logic. The host drains the waveform from the FIFO.

## Interface
- `FIFO_DEPTH`, 16: result FIFO entries; power of two, ≥ 2.
- `clk` in 1: system clock; same domain as the offset sampler's `clk`.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: sweep start; sampled only in IDLE.
- `abort` in 1: returns to IDLE from any state; highest priority.
- `num_steps` in 16: phase offsets to sample; latched on accepted `start`.
- `sampler_running` in 1: offset sampler busy (low only while it waits for a run request).
- `sampler_result_ready` in 1: one-cycle result strobe from the sampler.
- `sampler_result` in 32: sampler one-count, valid with the strobe.
- `sampler_request_run` out 1: run request to the sampler.
- `phase_step` out 1: one-cycle pulse requesting a one-increment ETS phase advance.
- `phase_step_ack` in 1: phase logic done; new phase stable.
- `busy` out 1: state ≠ IDLE.
- `sweep_done` out 1: one-cycle pulse at sweep completion.
- `step_index` out 16: offset currently being sampled.
- `fifo_rd` in 1: pop head entry.
- `fifo_clear` in 1: flush FIFO.
- `fifo_data` out 32: head entry, first-word fall-through; valid when `!fifo_empty`.
- `fifo_empty` out 1; `fifo_count` out $clog2(FIFO_DEPTH)+1.
- `overflow` out 1: sticky; a result was dropped because the FIFO was full.

## Operation
- **Reset values:**
  - Outputs: `sampler_request_run`, `phase_step`, `busy`, `sweep_done`, `step_index`, `fifo_count` and `overflow` are 0; `fifo_empty` is 1.
  - State: IDLE.
  - `fifo_data` is unchecked while `fifo_empty` is high.
- **States:** IDLE, ARM, REQUEST, WAIT_RESULT, STEP, WAIT_ACK, DONE.
- **IDLE:** on `start`:
  - latch `num_steps`, clear `step_index` and `overflow`;
  - go to DONE if the latched value is 0, else to ARM.
  - `start` in any other state is ignored.
- **ARM:** wait until `sampler_running`=0, then go to REQUEST. This guards against a sampler that is still leaving reset or finishing output.
- **REQUEST:** `sampler_request_run`=1 (Moore output); go to WAIT_RESULT on the first cycle `sampler_running`=1.
- **WAIT_RESULT:** on `sampler_result_ready`:
  - write `sampler_result` to the FIFO;
  - if `step_index` = latched `num_steps`−1, go to DONE, else go to STEP.
  - `sampler_result_ready` outside WAIT_RESULT is ignored.
- **STEP:** `phase_step`=1 for exactly this cycle; go to WAIT_ACK.
- **WAIT_ACK:** on `phase_step_ack`, increment `step_index` and go to ARM. An ack outside WAIT_ACK is ignored.
- **DONE:** `sweep_done`=1 for one cycle; go to IDLE.
- **abort:**
  - next state IDLE;
  - `sampler_request_run` and `phase_step` are low from the next cycle;
  - `step_index` cleared;
  - FIFO contents and `overflow` retained.
- **FIFO:**
  - circular buffer; read and write pointers wrap modulo `FIFO_DEPTH`.
  - Write when full and no read in the same cycle: data dropped, `overflow` set.
  - Simultaneous write and read when full: both succeed, count unchanged.
  - Read when empty: ignored; count stays 0.
  - `fifo_clear`: pointers and count go to 0 next cycle and override a same-cycle write or read. `overflow` is not cleared; only an accepted `start` or reset clears it.
- **Widths:** `step_index` never exceeds `num_steps`−1. `num_steps`=65535 is legal.

## Timing
- All outputs are registered or decoded from the state register; there are no combinational input-to-output paths except `fifo_data`/`fifo_empty` from pointer registers.
- `start` sampled at edge T: ARM from T+1; `sampler_request_run` high from T+2 at the earliest (only if `sampler_running` is low at T+1).
- `sampler_result_ready` at edge R: entry visible (`fifo_empty`=0, `fifo_count`+1) after R; STEP (`phase_step` high) in cycle R+1; WAIT_ACK from R+2.
- `phase_step_ack` at edge A: `step_index` incremented and ARM after A.
- Last result at edge R: `sweep_done` high in cycle R+1; IDLE with `busy`=0 from R+2.
- `num_steps`=0: `sweep_done` high in cycle T+1; no request is ever issued.

## Test plan
- Sweep with `num_steps`=4, sampler model returning 10, 20, 30, 40, ack 3 cycles after each `phase_step` → exactly 3 `phase_step` pulses, 4 requests, FIFO reads 10, 20, 30, 40, one `sweep_done`, `overflow`=0.
- `FIFO_DEPTH`=16, `num_steps`=20, no reads → `fifo_count`=16, `overflow`=1, first 16 values retained in order. Then `start` → `overflow` cleared.
- `num_steps`=0 → `sweep_done` one cycle after `start`, `sampler_request_run` never asserted.
- `sampler_running` held high (sampler in reset) at `start` → stays in ARM with request low; request asserts 1 cycle after running falls; a spurious `phase_step_ack` during ARM leaves `step_index` at 0.
- `abort` during WAIT_ACK with 2 entries stored → IDLE next cycle, `step_index`=0, `fifo_count`=2. Async `rst_n` pulse mid-sweep → all reset values immediately.
- FIFO full with simultaneous write and `fifo_rd` → count stays 16, oldest entry popped, no overflow. `fifo_clear` with simultaneous write → `fifo_count`=0.
